// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer: register offsets relative to
// BASE_LO, ctrl bit positions, mtimecmp reset value and the address decoder.
// No ports (package).
package machine_timer_pkg;

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_CMP_LO   = 8'h08;
  localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
  localparam logic [7:0] OFF_CTRL     = 8'h10;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

  // Byte-lane bits are masked off so any byte address inside a word selects it.
  function automatic reg_sel_e decode_reg(input logic [7:0] addr, input logic [7:0] base);
    logic [7:0] off;
    off = (addr & 8'hFC) - base;
    case (off)
      OFF_MTIME_LO: decode_reg = REG_MTIME_LO;
      OFF_MTIME_HI: decode_reg = REG_MTIME_HI;
      OFF_CMP_LO:   decode_reg = REG_CMP_LO;
      OFF_CMP_HI:   decode_reg = REG_CMP_HI;
      OFF_CTRL:     decode_reg = REG_CTRL;
      default:      decode_reg = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/machine_timer_if.sv
// Peripheral bus bundle for the machine timer (word access only).
//   bus_addr_in    8   byte offset, bits[1:0] ignored
//   bus_wr_en_in   1   write strobe
//   bus_rd_en_in   1   read strobe (ignored when bus_wr_en_in is also high)
//   bus_wdata_in   32  write data
//   bus_rdata_out  32  read data, valid with bus_rvalid_out
//   bus_rvalid_out 1   one-cycle pulse, one cycle after the read strobe
interface machine_timer_if;

  logic [7:0]  bus_addr_in;
  logic        bus_wr_en_in;
  logic        bus_rd_en_in;
  logic [31:0] bus_wdata_in;
  logic [31:0] bus_rdata_out;
  logic        bus_rvalid_out;

  modport master (
    output bus_addr_in, bus_wr_en_in, bus_rd_en_in, bus_wdata_in,
    input  bus_rdata_out, bus_rvalid_out
  );

  modport slave (
    input  bus_addr_in, bus_wr_en_in, bus_rd_en_in, bus_wdata_in,
    output bus_rdata_out, bus_rvalid_out
  );

endinterface

// File: rtl/machine_timer_prescaler.sv
// Prescaler for mtime: counts 0..PRESCALE-1 while enabled and emits a
// one-cycle tick on the last count. PRESCALE must be in 1..65535.
//   clk_in   in   clock
//   rst_in   in   synchronous active-high reset (count -> 0)
//   i_en     in   count enable; low freezes the count
//   i_clr    in   clear count to 0; suppresses the tick in the same cycle
//   o_tick   out  combinational tick pulse
module machine_timer_prescaler #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] r_count;

  assign o_tick = i_en && !i_clr && (r_count == LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tick ? 16'd0 : r_count + 16'd1;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime advanced by a prescaler, 64-bit mtimecmp,
// ctrl {ie, en}, and a registered level interrupt mtip_out.
//   clk_in         in   clock
//   rst_in         in   synchronous active-high reset
//   bus            slave modport of machine_timer_if (word register access)
//   real_time_out  out  mtime register, to the machine counter real_time_in
//   mtip_out       out  ie && (mtime >= mtimecmp), unsigned 64-bit
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned PRESCALE    = 16,
  parameter logic [63:0] MTIME_RESET = 64'h0,
  parameter logic [7:0]  BASE_LO     = 8'h00
) (
  input  logic            clk_in,
  input  logic            rst_in,
  machine_timer_if.slave  bus,
  output logic [63:0]     real_time_out,
  output logic            mtip_out
);

  logic [63:0] r_mtime;
  logic [63:0] r_cmp;
  logic        r_en;
  logic        r_ie;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_mtip;

  reg_sel_e    w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_mtime;
  logic        w_presc_clr;
  logic        w_tick;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_cmp_nxt;
  logic        w_en_nxt;
  logic        w_ie_nxt;
  logic [31:0] w_rdata_nxt;

  assign w_sel      = decode_reg(bus.bus_addr_in, BASE_LO);
  assign w_wr       = bus.bus_wr_en_in;
  // A simultaneous write takes the access; no read response is produced.
  assign w_rd       = bus.bus_rd_en_in && !bus.bus_wr_en_in;
  assign w_wr_mtime = w_wr && ((w_sel == REG_MTIME_LO) || (w_sel == REG_MTIME_HI));
  // Restart the prescale period on an mtime write or when counting is re-enabled.
  assign w_presc_clr = w_wr_mtime ||
                       (w_wr && (w_sel == REG_CTRL) && !r_en && bus.bus_wdata_in[CTRL_EN]);

  machine_timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_en   (r_en),
    .i_clr  (w_presc_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_mtime_nxt = r_mtime;
    w_cmp_nxt   = r_cmp;
    w_en_nxt    = r_en;
    w_ie_nxt    = r_ie;
    if (w_wr_mtime) begin
      if (w_sel == REG_MTIME_LO) w_mtime_nxt[31:0]  = bus.bus_wdata_in;
      else                       w_mtime_nxt[63:32] = bus.bus_wdata_in;
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
    if (w_wr) begin
      case (w_sel)
        REG_CMP_LO: w_cmp_nxt[31:0]  = bus.bus_wdata_in;
        REG_CMP_HI: w_cmp_nxt[63:32] = bus.bus_wdata_in;
        REG_CTRL: begin
          w_en_nxt = bus.bus_wdata_in[CTRL_EN];
          w_ie_nxt = bus.bus_wdata_in[CTRL_IE];
        end
        default: ;
      endcase
    end
  end

  // Read mux sees current register values, so a read on an updating edge
  // returns the pre-update value.
  always_comb begin
    w_rdata_nxt = '0;
    case (w_sel)
      REG_MTIME_LO: w_rdata_nxt = r_mtime[31:0];
      REG_MTIME_HI: w_rdata_nxt = r_mtime[63:32];
      REG_CMP_LO:   w_rdata_nxt = r_cmp[31:0];
      REG_CMP_HI:   w_rdata_nxt = r_cmp[63:32];
      REG_CTRL: begin
        w_rdata_nxt[CTRL_EN] = r_en;
        w_rdata_nxt[CTRL_IE] = r_ie;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_mtime  <= MTIME_RESET;
      r_cmp    <= MTIMECMP_RESET;
      r_en     <= 1'b1;
      r_ie     <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_mtip   <= 1'b0;
    end else begin
      r_mtime  <= w_mtime_nxt;
      r_cmp    <= w_cmp_nxt;
      r_en     <= w_en_nxt;
      r_ie     <= w_ie_nxt;
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rdata_nxt;
      // Compare on next-state values so mtip lines up with real_time_out.
      r_mtip   <= w_ie_nxt && (w_mtime_nxt >= w_cmp_nxt);
    end
  end

  assign real_time_out      = r_mtime;
  assign mtip_out           = r_mtip;
  assign bus.bus_rdata_out  = r_rdata;
  assign bus.bus_rvalid_out = r_rvalid;

endmodule

// File: tb/tb_machine_timer.sv
`timescale 1ns/1ps
module tb_machine_timer;
  import machine_timer_pkg::*;

  localparam int unsigned PRESCALE = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [63:0] real_time_out;
  logic        mtip_out;

  machine_timer_if bus_if ();

  machine_timer #(
    .PRESCALE    (PRESCALE),
    .MTIME_RESET (64'h0),
    .BASE_LO     (8'h00)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .bus           (bus_if),
    .real_time_out (real_time_out),
    .mtip_out      (mtip_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read-response monitor: pops one expectation per rvalid pulse.
  always @(negedge clk_in) begin
    exp_t e;
    if (bus_if.bus_rvalid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected rvalid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, " data"}, {32'd0, bus_if.bus_rdata_out}, {32'd0, e.data});
        chk({e.name, " latency"}, 64'(edge_cnt), 64'(e.due));
      end
    end
  end

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus_if.bus_addr_in  = a;
    bus_if.bus_wdata_in = d;
    bus_if.bus_wr_en_in = 1'b1;
    step();
    bus_if.bus_wr_en_in = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string name);
    exp_t x;
    x.data = e;
    x.due  = edge_cnt + 1;
    x.name = name;
    exp_q.push_back(x);
    bus_if.bus_addr_in  = a;
    bus_if.bus_rd_en_in = 1'b1;
    step();
    bus_if.bus_rd_en_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.bus_addr_in  = '0;
    bus_if.bus_wr_en_in = 1'b0;
    bus_if.bus_rd_en_in = 1'b0;
    bus_if.bus_wdata_in = '0;

    repeat (3) step();
    chk("reset mtime", real_time_out, 64'h0);
    chk("reset mtip", {63'd0, mtip_out}, 64'd0);
    chk("reset rvalid", {63'd0, bus_if.bus_rvalid_out}, 64'd0);
    chk("reset rdata", {32'd0, bus_if.bus_rdata_out}, 64'd0);
    rst_in = 1'b0;

    // 1: free run, one tick every 4th edge
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("t1 mtime", real_time_out, 64'(k / 4));
    end

    // 2: mtimecmp = 25, ie = 1 (edges 41..43)
    wr(OFF_CMP_HI, 32'h0);
    wr(OFF_CMP_LO, 32'd25);
    wr(OFF_CTRL, 32'h3);
    chk("t2 mtime after setup", real_time_out, 64'd10);
    for (int k = 44; k <= 102; k++) begin
      step();
      if (k >= 96) begin
        chk("t2 mtime", real_time_out, 64'(k / 4));
        chk("t2 mtip", {63'd0, mtip_out}, 64'(k >= 100));
      end
    end
    wr(OFF_CMP_HI, 32'h1);                       // edge 103
    chk("t2 mtip after cmp raise", {63'd0, mtip_out}, 64'd0);
    chk("t2 mtime after cmp raise", real_time_out, 64'd25);

    // 3: wrap through all-ones with ie cleared
    wr(OFF_CTRL, 32'h1);                         // edge 104, tick -> 26
    chk("t3 mtime", real_time_out, 64'd26);
    wr(OFF_MTIME_LO, 32'hFFFF_FFFF);             // edge 105
    chk("t3 mtime lo written", real_time_out, 64'h0000_0000_FFFF_FFFF);
    chk("t3 mtip lo", {63'd0, mtip_out}, 64'd0);
    wr(OFF_MTIME_HI, 32'hFFFF_FFFF);             // edge 106
    chk("t3 mtime all ones", real_time_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3 mtip hi", {63'd0, mtip_out}, 64'd0);
    for (int k = 107; k <= 110; k++) begin
      step();
      chk("t3 mtime wrap", real_time_out, (k < 110) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
      chk("t3 mtip", {63'd0, mtip_out}, 64'd0);
    end

    // 4: mtime write on a tick edge (edge 114)
    repeat (3) step();
    chk("t4 mtime before", real_time_out, 64'h0);
    wr(OFF_MTIME_LO, 32'h100);
    chk("t4 mtime written", real_time_out, 64'h100);
    for (int k = 115; k <= 118; k++) begin
      step();
      chk("t4 mtime", real_time_out, (k < 118) ? 64'h100 : 64'h101);
    end

    // 5: freeze for 20 edges, re-enable restarts the period
    wr(OFF_CTRL, 32'h0);                         // edge 119
    chk("t5 mtime at disable", real_time_out, 64'h101);
    for (int k = 120; k <= 139; k++) begin
      step();
      chk("t5 mtime frozen", real_time_out, 64'h101);
    end
    wr(OFF_CTRL, 32'h1);                         // edge 140
    for (int k = 141; k <= 144; k++) begin
      step();
      chk("t5 mtime resume", real_time_out, (k < 144) ? 64'h101 : 64'h102);
    end

    // 6: register reads (edges 145..150), pre-update read on tick edge 152
    rd(OFF_MTIME_LO, 32'h102, "rd mtime lo");
    rd(OFF_MTIME_HI, 32'h0, "rd mtime hi");
    rd(OFF_CMP_LO, 32'd25, "rd cmp lo");
    rd(OFF_CMP_HI, 32'h1, "rd cmp hi");
    rd(OFF_CTRL, 32'h1, "rd ctrl");
    rd(8'h20, 32'h0, "rd unmapped");
    step();
    rd(OFF_MTIME_LO, 32'h103, "rd mtime lo on tick");

    // write and read together: write only, no response (edge 153)
    bus_if.bus_addr_in  = OFF_CTRL;
    bus_if.bus_wdata_in = 32'h3;
    bus_if.bus_wr_en_in = 1'b1;
    bus_if.bus_rd_en_in = 1'b1;
    step();
    bus_if.bus_wr_en_in = 1'b0;
    bus_if.bus_rd_en_in = 1'b0;
    wr(8'h20, 32'hDEAD_BEEF);                    // edge 154, ignored
    rd(8'h20, 32'h0, "rd unmapped after wr");    // edge 155
    rd(OFF_CTRL, 32'h3, "rd ctrl after wr+rd");  // edge 156
    wr(OFF_CMP_HI, 32'h0);                       // edge 157, cmp = 25
    chk("t6 mtip asserted", {63'd0, mtip_out}, 64'd1);

    // reset arriving with a read strobe (edge 158)
    rst_in = 1'b1;
    bus_if.bus_addr_in  = OFF_MTIME_LO;
    bus_if.bus_rd_en_in = 1'b1;
    step();
    bus_if.bus_rd_en_in = 1'b0;
    chk("rst rvalid", {63'd0, bus_if.bus_rvalid_out}, 64'd0);
    chk("rst mtime", real_time_out, 64'h0);
    chk("rst mtip", {63'd0, mtip_out}, 64'd0);
    chk("rst rdata", {32'd0, bus_if.bus_rdata_out}, 64'd0);
    step();
    chk("rst rvalid held", {63'd0, bus_if.bus_rvalid_out}, 64'd0);
    rst_in = 1'b0;

    rd(OFF_CTRL, 32'h1, "rd ctrl after reset");
    rd(OFF_CMP_HI, 32'hFFFF_FFFF, "rd cmp hi after reset");
    rd(OFF_CMP_LO, 32'hFFFF_FFFF, "rd cmp lo after reset");
    rd(OFF_MTIME_LO, 32'h0, "rd mtime lo first tick edge");
    rd(OFF_MTIME_LO, 32'h1, "rd mtime lo after first tick");
    step();
    step();
    chk("pending reads", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
